// File: rtl/time_counter.sv
// Time-of-day counter: turns clk_N rising edges into one-second ticks and keeps
// packed-BCD hh:mm:ss with a RUN/SET_HOUR/SET_MIN setting machine.
// Define TIME_COUNTER_12H_EN for a 12-hour clock with a PM flag.
module time_counter #(
  parameter logic [7:0] HOUR_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_N,
  input  logic       mode,
  input  logic       inc,
  input  logic       pause,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] state,
  output logic       pm,
  output logic       day_carry
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       carry_q, carry_d;
  logic       pm_q, pm_d;
  logic       s1, s2, s3;
  logic       tick;

  // Increment one packed-BCD field; range wrap is handled by the callers.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] sixty_inc(input logic [7:0] v);
    return (v == 8'h59) ? 8'h00 : bcd_inc(v);
  endfunction

  function automatic logic [7:0] hour_inc(input logic [7:0] h);
`ifdef TIME_COUNTER_12H_EN
    return (h == 8'h12) ? 8'h01 : bcd_inc(h);
`else
    return (h == 8'h23) ? 8'h00 : bcd_inc(h);
`endif
  endfunction

  // s1/s2 resynchronise the divider output; s3 is history for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours and the chain behaves as a shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_N;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  // NOTE: every variable gets its hold value first so no branch can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pm_d    = pm_q;
    carry_d = 1'b0;

    case (state_q)
      RUN: begin
        if (tick && !pause) begin
          if (sec_q == 8'h59) begin
            sec_d = 8'h00;
            if (min_q == 8'h59) begin
              min_d  = 8'h00;
              hour_d = hour_inc(hour_q);
`ifdef TIME_COUNTER_12H_EN
              // 11:59:59 -> 12:00:00 flips AM/PM; only leaving PM starts a new day.
              if (hour_q == 8'h11) begin
                pm_d    = ~pm_q;
                carry_d = pm_q;
              end
`else
              carry_d = (hour_q == 8'h23);
`endif
            end else begin
              min_d = bcd_inc(min_q);
            end
          end else begin
            sec_d = bcd_inc(sec_q);
          end
        end
        // A tick in the same cycle is still applied above.
        if (mode) state_d = SET_HOUR;
      end

      SET_HOUR: begin
        if (mode) begin
          state_d = SET_MIN;
        end else if (inc) begin
          hour_d = hour_inc(hour_q);
`ifdef TIME_COUNTER_12H_EN
          if (hour_q == 8'h11) pm_d = ~pm_q;
`endif
        end
      end

      SET_MIN: begin
        if (mode) begin
          state_d = RUN;
          sec_d   = 8'h00;
        end else if (inc) begin
          min_d = sixty_inc(min_q);
        end
      end

      default: state_d = RUN;
    endcase
  end

  // NOTE: only control and time registers exist here, so all of them take the
  // asynchronous reset; there is no storage array to leave unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      hour_q  <= HOUR_RESET;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      carry_q <= 1'b0;
      pm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      carry_q <= carry_d;
      pm_q    <= pm_d;
    end
  end

  assign hour_bcd  = hour_q;
  assign min_bcd   = min_q;
  assign sec_bcd   = sec_q;
  assign state     = state_q;
  assign day_carry = carry_q;
`ifdef TIME_COUNTER_12H_EN
  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Directed self-checking bench for time_counter (24-hour build by default,
// 12-hour scenarios when TIME_COUNTER_12H_EN is defined).
module tb_time_counter;

`ifdef TIME_COUNTER_12H_EN
  localparam logic [7:0] RST_HOUR = 8'h12;
`else
  localparam logic [7:0] RST_HOUR = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_N;
  logic       mode;
  logic       inc;
  logic       pause;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] state;
  logic       pm;
  logic       day_carry;

  int n_cmp = 0;
  int n_err = 0;

  time_counter #(.HOUR_RESET(RST_HOUR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_N     (clk_N),
    .mode      (mode),
    .inc       (inc),
    .pause     (pause),
    .hour_bcd  (hour_bcd),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .state     (state),
    .pm        (pm),
    .day_carry (day_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    check({tag, ".hour"}, {24'd0, hour_bcd}, {24'd0, h});
    check({tag, ".min"},  {24'd0, min_bcd},  {24'd0, m});
    check({tag, ".sec"},  {24'd0, sec_bcd},  {24'd0, s});
  endtask

  // All tasks begin and end at a falling clock edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_mode();
    mode = 1'b1;
    step(1);
    mode = 1'b0;
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      inc = 1'b1;
      step(1);
      inc = 1'b0;
      step(1);
    end
  endtask

  task automatic slow_edge();
    clk_N = 1'b1;
    step(4);
    clk_N = 1'b0;
    step(4);
  endtask

  // One clk_N period; returns day_carry as seen in the cycle the time updates.
  task automatic tick_edge(output logic dc_seen);
    clk_N = 1'b1;
    step(3);
    dc_seen = day_carry;
    clk_N = 1'b0;
    step(5);
  endtask

  task automatic set_time(input int hour_incs, input int min_incs);
    pulse_mode();
    pulse_inc(hour_incs);
    pulse_mode();
    pulse_inc(min_incs);
    pulse_mode();
  endtask

  logic dc;

  initial begin
    rst_n = 1'b0;
    clk_N = 1'b0;
    mode  = 1'b0;
    inc   = 1'b0;
    pause = 1'b0;
    step(2);
    check_time("reset", RST_HOUR, 8'h00, 8'h00);
    check("reset.state", {30'd0, state}, 32'd0);
    check("reset.pm", {31'd0, pm}, 32'd0);
    check("reset.day_carry", {31'd0, day_carry}, 32'd0);
    rst_n = 1'b1;
    step(2);

`ifndef TIME_COUNTER_12H_EN
    slow_edge();
    check_time("first_tick", 8'h00, 8'h00, 8'h01);
    pulse_inc(1);
    check_time("inc_in_run", 8'h00, 8'h00, 8'h01);

    // Setting: hours 00->03, collision into SET_MIN, minutes +61 -> 01.
    pulse_mode();
    check("set.state_hour", {30'd0, state}, 32'd1);
    pulse_inc(3);
    check("set.hour3", {24'd0, hour_bcd}, 32'h03);
    slow_edge();
    check_time("tick_in_set_hour", 8'h03, 8'h00, 8'h01);
    mode = 1'b1;
    inc  = 1'b1;
    step(1);
    mode = 1'b0;
    inc  = 1'b0;
    check("collide.state", {30'd0, state}, 32'd2);
    check("collide.hour", {24'd0, hour_bcd}, 32'h03);
    pulse_inc(61);
    check_time("set.min61", 8'h03, 8'h01, 8'h01);
    slow_edge();
    check("tick_in_set_min.sec", {24'd0, sec_bcd}, 32'h01);
    pulse_mode();
    check("set.back_to_run", {30'd0, state}, 32'd0);
    check_time("set.done", 8'h03, 8'h01, 8'h00);

    // Pause at 10:00:00.
    set_time(7, 59);
    check_time("preset_10", 8'h10, 8'h00, 8'h00);
    pause = 1'b1;
    repeat (3) slow_edge();
    check_time("paused", 8'h10, 8'h00, 8'h00);
    pause = 1'b0;
    slow_edge();
    check_time("unpaused", 8'h10, 8'h00, 8'h01);

    // Tick and mode land in the same cycle: tick applied, state advances.
    clk_N = 1'b1;
    step(2);
    check("tick_mode.before", {24'd0, sec_bcd}, 32'h01);
    mode = 1'b1;
    step(1);
    mode = 1'b0;
    check("tick_mode.sec", {24'd0, sec_bcd}, 32'h02);
    check("tick_mode.state", {30'd0, state}, 32'd1);
    clk_N = 1'b0;
    step(4);
    pulse_mode();
    pulse_mode();
    check_time("exit_set_clears_sec", 8'h10, 8'h00, 8'h00);

    // Asynchronous reset mid-count at 05:17:42 (10 + 19 wraps to 05).
    set_time(19, 17);
    repeat (42) slow_edge();
    check_time("count_05_17_42", 8'h05, 8'h17, 8'h42);
    #2 rst_n = 1'b0;
    #1;
    check_time("async_reset", 8'h00, 8'h00, 8'h00);
    check("async_reset.state", {30'd0, state}, 32'd0);
    check("async_reset.day_carry", {31'd0, day_carry}, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // Day wrap 23:59:58 -> 23:59:59 -> 00:00:00 with edge-accurate timing.
    set_time(23, 59);
    repeat (58) slow_edge();
    check_time("preset_23_59_58", 8'h23, 8'h59, 8'h58);
    clk_N = 1'b1;
    step(2);
    check("wrap1.latency", {24'd0, sec_bcd}, 32'h58);
    step(1);
    check_time("wrap1", 8'h23, 8'h59, 8'h59);
    check("wrap1.day_carry", {31'd0, day_carry}, 32'd0);
    clk_N = 1'b0;
    step(4);
    clk_N = 1'b1;
    step(2);
    check("wrap2.latency", {24'd0, sec_bcd}, 32'h59);
    step(1);
    check_time("wrap2", 8'h00, 8'h00, 8'h00);
    check("wrap2.day_carry", {31'd0, day_carry}, 32'd1);
    step(1);
    check("wrap2.day_carry_drop", {31'd0, day_carry}, 32'd0);
    clk_N = 1'b0;
    step(4);
    check("pm_24h", {31'd0, pm}, 32'd0);
`else
    // 11:59:59 AM -> 12:00:00 PM, no day_carry.
    set_time(11, 59);
    check("am.pm_before", {31'd0, pm}, 32'd0);
    repeat (59) slow_edge();
    check_time("am_11_59_59", 8'h11, 8'h59, 8'h59);
    tick_edge(dc);
    check_time("noon", 8'h12, 8'h00, 8'h00);
    check("noon.pm", {31'd0, pm}, 32'd1);
    check("noon.day_carry", {31'd0, dc}, 32'd0);

    // 11:59:59 PM -> 12:00:00 AM with day_carry.
    set_time(11, 59);
    check("pm.hour11", {24'd0, hour_bcd}, 32'h11);
    check("pm.flag", {31'd0, pm}, 32'd1);
    repeat (59) slow_edge();
    check_time("pm_11_59_59", 8'h11, 8'h59, 8'h59);
    tick_edge(dc);
    check_time("midnight", 8'h12, 8'h00, 8'h00);
    check("midnight.pm", {31'd0, pm}, 32'd0);
    check("midnight.day_carry", {31'd0, dc}, 32'd1);
    check("midnight.day_carry_drop", {31'd0, day_carry}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/time_counter.md
# time_counter

Time-of-day counter that sits directly downstream of the clock divider. It samples the divider's slow square wave `clk_N` in the system clock domain and turns each rising edge into a one-second tick. It keeps hours, minutes and seconds in packed BCD, and provides a mode/increment state machine for setting the time. Outputs feed the seven-segment display driver.

## Interface
- `HOUR_RESET`, default 8'h00: BCD hour loaded on reset. In 12-hour builds it must be a legal value 01–12; 8'h12 is typical.
- `clk`  in  1  system clock; all state is updated on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `clk_N`  in  1  slow square wave from the divider; treated as asynchronous.
- `mode`  in  1  debounced single-cycle pulse that advances the set state machine.
- `inc`  in  1  debounced single-cycle pulse that increments the selected field while setting.
- `pause`  in  1  level input; while high in RUN, ticks are discarded.
- `hour_bcd`  out  8  hours, packed BCD.
- `min_bcd`  out  8  minutes, packed BCD.
- `sec_bcd`  out  8  seconds, packed BCD.
- `state`  out  2  current state: 2'd0 RUN, 2'd1 SET_HOUR, 2'd2 SET_MIN.
- `pm`  out  1  PM flag; tied to 0 unless the 12-hour feature is compiled in.
- `day_carry`  out  1  one-cycle pulse when the time wraps to the start of the day.

## Operation
- **Tick generation:** `clk_N` passes through a 2-FF synchronizer plus a history FF (s1, s2, s3); `tick = s2 & ~s3`.
  - Exactly one tick per `clk_N` rising edge.
  - Falling edges are ignored.
- **RUN state:** each tick with `pause` low increments `sec_bcd`.
  - Seconds 59→00 carries into minutes.
  - Minutes 59→00 carries into hours.
  - 24-hour hours run 00..23, then back to 00.
- **BCD rule:** units digit 9→0 increments the tens digit; no field ever holds a non-BCD or out-of-range code.
- **day_carry:** asserted for one cycle on the 23:59:59→00:00:00 transition.
- **State machine:** a `mode` pulse moves RUN→SET_HOUR→SET_MIN→RUN.
  - Leaving SET_MIN to RUN clears `sec_bcd` to 8'h00.
  - Ticks are discarded in SET_HOUR and SET_MIN.
- **inc while setting:**
  - In SET_HOUR, increments hours with wrap and no carry into anything else.
  - In SET_MIN, increments minutes 59→00 with no carry into hours.
  - Ignored in RUN.
  - Never asserts `day_carry`.
- **Simultaneous events:**
  - `mode` and `inc` in the same cycle: `mode` wins and `inc` is dropped.
  - `tick` and `mode` in the same cycle in RUN: the tick is applied and the state advances.
- **Reset:** asynchronous and valid at any time, including mid-set.
  - Time becomes `HOUR_RESET`:00:00.
  - `state` = RUN, `pm` = 0, `day_carry` = 0.
  - s1/s2/s3 = 0, so if `clk_N` is high at reset release, one tick follows two cycles later.

## Timing
- If `clk_N` is high at clock edge k (s1 captures it), `tick` is high in the cycle after edge k+1, and time outputs change at edge k+2.
- `mode` or `inc` sampled high at edge k: `state` or the affected field changes at edge k, visible in the following cycle.
- `day_carry` is registered and is high in the same cycle the outputs first show the wrapped time.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `TIME_COUNTER_12H_EN` defined: 12-hour mode.
  - Hours run 12, 01..11.
  - `pm` toggles on 11:59:59→12:00:00.
  - `day_carry` fires only on 11:59:59 PM→12:00:00 AM.
  - SET_HOUR `inc` steps 12→01→…→11→12 and toggles `pm` on 11→12.
- `TIME_COUNTER_12H_EN` undefined: 24-hour mode as described in Operation; `pm` is constant 0.

## Test plan
- **Reset:** assert `rst_n` mid-count at 05:17:42 → outputs immediately read 00:00:00, `state` = 0, `day_carry` = 0.
- **Day wrap:** preset 23:59:58, drive two `clk_N` rising edges → 23:59:59, then 00:00:00 with a single-cycle `day_carry`. Each update lands exactly 2 `clk` cycles after the edge where s1 captured high.
- **Pause:** `pause` high across 3 `clk_N` edges at 10:00:00 → time unchanged; after release, the next edge gives 10:00:01.
- **Set sequence:** `mode`, then 3×`inc` → hours 00→03. Then `mode`, then 61×`inc` → minutes 01 with hours still 03. Then `mode` → RUN at 03:01:00. Ticks during setting are ignored.
- **Collision:** `mode` and `inc` in the same cycle in SET_HOUR → state becomes SET_MIN and hours are unchanged.
- **12-hour build:** preset 11:59:59 PM, one tick → 12:00:00 with `pm` = 0 and `day_carry` pulsed. From 11:59:59 AM, one tick → 12:00:00 with `pm` = 1 and no `day_carry`.
